// File: rtl/binder_lanes_hf.sv
// binder_lanes_hf: multi-lane hypervector binder.
// Binds hv1 with a (possibly inverted or rotated) hv2, LANES bits per cycle,
// writing one chunk of hv_out per RUN cycle. Used between the item/level
// memories and the bundler in the HDC encoder.
module binder_lanes_hf #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned LANES      = 1,
  localparam int unsigned SW        = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SW-1:0]         shift_amt,
  input  logic [DIMENSIONS-1:0] hv1,
  input  logic [DIMENSIONS-1:0] hv2,
  output logic                  out,
  output logic                  done,
  output logic [DIMENSIONS-1:0] hv_out
);

  localparam int unsigned NCHUNK = (DIMENSIONS + LANES - 1) / LANES;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ModeXnor = 2'b01;
  localparam logic [1:0] ModeRot  = 2'b10;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [SW-1:0]         shift_q, shift_d;
  logic                  done_q, done_d;
  logic [DIMENSIONS-1:0] hv_q, hv_d;

  logic                  last_chunk;
  logic [SW-1:0]         shift_wrapped;
  logic [31:0]           bit_idx;
  logic [31:0]           src_idx;
  logic                  b_bit;

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // shift_amt can encode values up to 2^SW-1 < 2*D, so one subtraction folds it.
  assign shift_wrapped = (32'(shift_amt) >= DIMENSIONS) ?
                         (shift_amt - SW'(DIMENSIONS)) : shift_amt;

  // Control FSM: start on en in IDLE, step through chunks, pulse done on exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRun;
          cnt_d   = '0;
          mode_d  = mode;
          shift_d = shift_wrapped;
        end
      end
      StRun: begin
        if (last_chunk) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: compute the current chunk of bound bits; lanes past D are masked.
  always_comb begin
    hv_d    = hv_q;
    bit_idx = '0;
    src_idx = '0;
    b_bit   = 1'b0;
    if (state_q == StRun) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        bit_idx = 32'(cnt_q) * LANES + j;
        if (bit_idx < DIMENSIONS) begin
          if (mode_q == ModeRot) begin
            // Left rotation of hv2: result bit i takes source bit (i - shift) mod D.
            src_idx = (bit_idx >= 32'(shift_q)) ? (bit_idx - 32'(shift_q))
                                                : (bit_idx + DIMENSIONS - 32'(shift_q));
          end else begin
            src_idx = bit_idx;
          end
          b_bit = hv2[src_idx[SW-1:0]];
          hv_d[bit_idx[SW-1:0]] = hv1[bit_idx[SW-1:0]] ^ b_bit ^ (mode_q == ModeXnor);
        end
      end
    end
  end

  // State and result registers; reset aborts any run and clears the result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      hv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      hv_q    <= hv_d;
    end
  end

  assign out    = (state_q == StIdle);
  assign done   = done_q;
  assign hv_out = hv_q;

endmodule

// File: tb/tb_binder_lanes_hf.sv
// Scoreboard bench for binder_lanes_hf: one D=16/L=4 instance plus two D=10
// instances (L=4 and L=1) sharing stimulus. Expected results are queued at
// start; monitors pop and compare whenever done pulses.
module tb_binder_lanes_hf;

  typedef struct {
    logic [15:0] hv;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        nrst;

  logic        a_en;
  logic [1:0]  a_mode;
  logic [3:0]  a_shift;
  logic [15:0] a_hv1, a_hv2, a_hv;
  logic        a_out, a_done;

  logic        bc_en;
  logic [1:0]  bc_mode;
  logic [3:0]  bc_shift;
  logic [9:0]  bc_hv1, bc_hv2, b_hv, c_hv;
  logic        b_out, b_done, c_out, c_done;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int n_cmp = 0;
  int n_err = 0;

  binder_lanes_hf #(.DIMENSIONS(16), .LANES(4)) u_a (
    .clk(clk), .nrst(nrst), .en(a_en), .mode(a_mode), .shift_amt(a_shift),
    .hv1(a_hv1), .hv2(a_hv2), .out(a_out), .done(a_done), .hv_out(a_hv)
  );

  binder_lanes_hf #(.DIMENSIONS(10), .LANES(4)) u_b (
    .clk(clk), .nrst(nrst), .en(bc_en), .mode(bc_mode), .shift_amt(bc_shift),
    .hv1(bc_hv1), .hv2(bc_hv2), .out(b_out), .done(b_done), .hv_out(b_hv)
  );

  binder_lanes_hf #(.DIMENSIONS(10), .LANES(1)) u_c (
    .clk(clk), .nrst(nrst), .en(bc_en), .mode(bc_mode), .shift_amt(bc_shift),
    .hv1(bc_hv1), .hv2(bc_hv2), .out(c_out), .done(c_done), .hv_out(c_hv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor for instance A.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        run = 0;
      end else begin
        if (!a_out) run++;
        if (a_done) begin
          if (q_a.size() == 0) begin
            check("a_extra_done", 16'(a_done), 16'd0);
          end else begin
            e = q_a.pop_front();
            check("a_hv_out", a_hv, e.hv);
            check("a_run_cycles", 16'(run), 16'(e.cyc));
            check("a_out_on_done", 16'(a_out), 16'd1);
          end
          run = 0;
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        run = 0;
      end else begin
        if (!b_out) run++;
        if (b_done) begin
          if (q_b.size() == 0) begin
            check("b_extra_done", 16'(b_done), 16'd0);
          end else begin
            e = q_b.pop_front();
            check("b_hv_out", 16'(b_hv), e.hv);
            check("b_run_cycles", 16'(run), 16'(e.cyc));
          end
          run = 0;
        end
      end
    end
  end

  // Monitor for instance C.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        run = 0;
      end else begin
        if (!c_out) run++;
        if (c_done) begin
          if (q_c.size() == 0) begin
            check("c_extra_done", 16'(c_done), 16'd0);
          end else begin
            e = q_c.pop_front();
            check("c_hv_out", 16'(c_hv), e.hv);
            check("c_run_cycles", 16'(run), 16'(e.cyc));
          end
          run = 0;
        end
      end
    end
  end

  task automatic start_a(input logic [1:0] m, input logic [3:0] sh,
                         input logic [15:0] h1, input logic [15:0] h2,
                         input logic [15:0] exp_hv);
    a_mode  = m;
    a_shift = sh;
    a_hv1   = h1;
    a_hv2   = h2;
    a_en    = 1'b1;
    q_a.push_back('{hv: exp_hv, cyc: 4});
    @(posedge clk);
    #1;
    a_en = 1'b0;
  endtask

  task automatic drain_a();
    for (int k = 0; k < 40; k++) begin
      if (q_a.size() == 0) break;
      @(posedge clk);
    end
    if (q_a.size() != 0) begin
      check("a_timeout", 16'(q_a.size()), 16'd0);
      q_a.delete();
    end
    #1;
  endtask

  task automatic start_bc(input logic [1:0] m, input logic [3:0] sh,
                          input logic [9:0] h1, input logic [9:0] h2,
                          input logic [9:0] exp_hv);
    bc_mode  = m;
    bc_shift = sh;
    bc_hv1   = h1;
    bc_hv2   = h2;
    bc_en    = 1'b1;
    q_b.push_back('{hv: 16'(exp_hv), cyc: 3});
    q_c.push_back('{hv: 16'(exp_hv), cyc: 10});
    @(posedge clk);
    #1;
    bc_en = 1'b0;
  endtask

  task automatic drain_bc();
    for (int k = 0; k < 40; k++) begin
      if (q_b.size() == 0 && q_c.size() == 0) break;
      @(posedge clk);
    end
    if (q_b.size() != 0 || q_c.size() != 0) begin
      check("bc_timeout", 16'(q_b.size() + q_c.size()), 16'd0);
      q_b.delete();
      q_c.delete();
    end
    #1;
  endtask

  initial begin
    nrst     = 1'b0;
    a_en     = 1'b0;
    a_mode   = 2'b00;
    a_shift  = '0;
    a_hv1    = '0;
    a_hv2    = '0;
    bc_en    = 1'b0;
    bc_mode  = 2'b00;
    bc_shift = '0;
    bc_hv1   = '0;
    bc_hv2   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out", 16'(a_out), 16'd1);
    check("rst_a_done", 16'(a_done), 16'd0);
    check("rst_a_hv", a_hv, 16'h0000);
    check("rst_b_hv", 16'(b_hv), 16'h0000);
    check("rst_c_out", 16'(c_out), 16'd1);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Basic modes on D=16, L=4.
    start_a(2'b00, 4'd0,  16'hF0F0, 16'hFF00, 16'h0FF0); drain_a();
    start_a(2'b01, 4'd0,  16'hF0F0, 16'hFF00, 16'hF00F); drain_a();
    start_a(2'b10, 4'd4,  16'h0000, 16'h000F, 16'h00F0); drain_a();
    start_a(2'b10, 4'd0,  16'h0000, 16'h000F, 16'h000F); drain_a();
    start_a(2'b10, 4'd12, 16'h0000, 16'h000F, 16'hF000); drain_a();
    start_a(2'b10, 4'd1,  16'hFFFF, 16'h8001, 16'hFFFC); drain_a();
    start_a(2'b11, 4'd4,  16'hF0F0, 16'hFF00, 16'h0FF0); drain_a();

    // Mode/shift changes mid-run must not affect the current run.
    start_a(2'b10, 4'd4, 16'h0000, 16'h000F, 16'h00F0);
    a_mode  = 2'b01;
    a_shift = 4'd8;
    drain_a();

    // Reset during RUN cycle 2 aborts and clears the result immediately.
    start_a(2'b00, 4'd0, 16'hFFFF, 16'h0000, 16'hFFFF);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("abort_hv", a_hv, 16'h0000);
    check("abort_out", 16'(a_out), 16'd1);
    check("abort_done", 16'(a_done), 16'd0);
    q_a.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    start_a(2'b00, 4'd0, 16'hF0F0, 16'hFF00, 16'h0FF0); drain_a();

    // en held high: back-to-back runs, mode change lands on the second run.
    a_mode = 2'b00;
    a_hv1  = 16'hF0F0;
    a_hv2  = 16'hFF00;
    a_en   = 1'b1;
    q_a.push_back('{hv: 16'h0FF0, cyc: 4});
    q_a.push_back('{hv: 16'hF00F, cyc: 4});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    a_mode = 2'b01;
    for (int k = 0; k < 20; k++) begin
      if (a_done) break;
      @(posedge clk);
      #1;
    end
    check("b2b_done_seen", 16'(a_done), 16'd1);
    @(posedge clk);
    #1;
    check("b2b_one_idle_gap", 16'(a_out), 16'd0);
    a_en = 1'b0;
    drain_a();

    // D=10 with partial last chunk (L=4) and bit-serial (L=1).
    start_bc(2'b00, 4'd0,  10'h3FF, 10'h000, 10'h3FF); drain_bc();
    start_bc(2'b10, 4'd12, 10'h000, 10'h201, 10'h006); drain_bc();
    start_bc(2'b01, 4'd0,  10'h3FF, 10'h0F0, 10'h0F0); drain_bc();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
